pdh_cmd_ctrl: RTL and testbench
===============================

# pdh_cmd_ctrl

Command sequencer between the PS GPIO word pair and `pdh_core`. It decodes a toggle-strobed 32-bit command word from the PS, applies register writes to a bank of configuration registers driving the PDH datapath, and serves reads and single-sample ADC snapshots. It returns a status/readback word with a matching acknowledge toggle. It sits in the `pdh_clk` domain between `axi_from_ps`/`axi_to_ps` and the `pdh_core` configuration inputs.

## Interface
- `NUM_REGS`, 8: number of config registers (max 16).
- `REG_WIDTH`, 16: bits per config register.
- `SETTLE_CYCLES`, 4: bus-settle wait after strobe detect (1..255).
- `TIMEOUT_CYCLES`, 1024: SNAP wait limit for `S_AXIS_tvalid_i` (1..65535).

Ports:
- `clk`  in  1  `pdh_clk`; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `axi_from_ps_i`  in  32  command word: [31] strobe, [30:28] opcode, [27:24] addr, [15:0] data; [23:16] ignored.
- `axi_to_ps_o`  out  32  response word: [31] ack, [30:28] status, [27:24] echoed addr, [23:16] zero, [15:0] readback.
- `S_AXIS_tdata_i`  in  32  ADC stream: [15:0] ch A, [31:16] ch B.
- `S_AXIS_tvalid_i`  in  1  ADC sample valid.
- `cfg_o`  out  NUM_REGS*REG_WIDTH  flattened register bank; reg i at [i*REG_WIDTH +: REG_WIDTH].
- `cfg_wr_o`  out  1  one-cycle pulse on each completed WRITE.
- `cfg_addr_o`  out  4  address of the last WRITE.
- `busy_o`  out  1  high in every state except IDLE.

## Operation
- `axi_from_ps_i` passes through a 2-flop synchronizer on all 32 bits.
- Opcodes: 000 NOP, 001 WRITE, 010 READ, 011 SNAP; 1xx is invalid.
- Status codes: 000 OK, 001 bad opcode, 010 bad address, 011 SNAP timeout.
- FSM states are IDLE, SETTLE, EXEC and RESP.
- **IDLE**
  - Synchronized strobe ≠ ack register → go to SETTLE and clear the counter.
- **SETTLE**
  - Count SETTLE_CYCLES cycles.
  - On the last cycle, latch the whole synchronized word (strobe, opcode, addr, data) into the command register, then go to EXEC.
- **EXEC**
  - NOP: status OK, readback 0.
  - WRITE with addr < NUM_REGS: `cfg_o[addr]` ← data[REG_WIDTH-1:0]; pulse `cfg_wr_o`; `cfg_addr_o` ← addr; status OK; readback = written value, zero-extended.
  - READ with addr < NUM_REGS: readback = `cfg_o[addr]`; status OK.
  - WRITE or READ with addr ≥ NUM_REGS: status 010, no write, readback 0.
  - SNAP addr 0: stay in EXEC until `S_AXIS_tvalid_i`=1, then readback = ch A.
  - SNAP addr 1: as addr 0, but readback = ch B.
  - SNAP addr > 1: status 010 immediately.
  - SNAP timeout: counter reaches TIMEOUT_CYCLES without valid → status 011, readback 0.
  - Invalid opcode: status 001, readback 0.
  - Leaving EXEC updates `axi_to_ps_o`[30:0] (status, echoed addr, readback).
- **RESP**
  - Lasts one cycle, so the data fields are stable before the ack changes.
  - Leaving RESP sets the ack register (`axi_to_ps_o`[31]) to the latched strobe value; next state is IDLE.
- Strobe changes during SETTLE, EXEC or RESP are ignored. After the return to IDLE, a synchronized strobe ≠ ack starts a new command using the bus value present then.
- Reset mid-command abandons it: no write and no ack. If the PS strobe is already 1 at reset release, a command runs.

## Timing
- Reset values: `axi_to_ps_o`=0, `cfg_o`=0, `cfg_wr_o`=0, `cfg_addr_o`=0, `busy_o`=0, ack register=0; state IDLE.
- Input synchronizer latency: 2 cycles from pin to IDLE compare.
- Counted from the edge entering SETTLE (SNAP counts only its immediate cases):
  - `cfg_o`/`cfg_wr_o`/response fields update at edge SETTLE_CYCLES+1.
  - Ack toggles at edge SETTLE_CYCLES+2.
  - A new command can be detected from edge SETTLE_CYCLES+3.
- SNAP adds one cycle per EXEC wait cycle.
  - If tvalid is already high on the first EXEC cycle, there is no extra delay.
  - The timeout path adds exactly TIMEOUT_CYCLES cycles.
- `cfg_wr_o` is high for exactly one cycle, coincident with the `cfg_o` update.

## Configuration
- Macro `PDH_CMD_READBACK_EN`.
- Defined: READ behaves as above.
- Undefined: READ is treated as an invalid opcode (status 001, readback 0). The read mux is not synthesized.

## Test plan
- Reset, then strobe 0→1 with WRITE addr 3 data 0x1234 → `cfg_o` reg3=0x1234, `cfg_wr_o` one pulse, `cfg_addr_o`=3, then ack=1 with status 000, readback 0x1234, ack at SETTLE_CYCLES+2 cycles.
- READ addr 3 (strobe 1→0) → readback 0x1234, status 000, ack=0. Without `PDH_CMD_READBACK_EN`: status 001, readback 0.
- WRITE addr 9 with NUM_REGS=8 → status 010, `cfg_o` unchanged, no `cfg_wr_o`.
- SNAP addr 1, tvalid asserted after 10 cycles with tdata=0xBEEF_0042 → readback 0xBEEF, status 000. Repeat with tvalid held low → status 011 after TIMEOUT_CYCLES.
- Opcode 101 → status 001. Toggle strobe twice during SETTLE → exactly one command executes, then one more follows if the final strobe ≠ ack.
- Assert rst_n low during SNAP wait → all outputs return to reset values; no ack is issued.

Source files
------------

// File: rtl/pdh_cmd_ctrl.sv
// rtl/pdh_cmd_ctrl.sv - PS command sequencer driving the pdh_core config bank
// Optional READ opcode support is enabled by defining PDH_CMD_READBACK_EN.
module pdh_cmd_ctrl #(
    parameter int NUM_REGS       = 8,
    parameter int REG_WIDTH      = 16,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [31:0]                   axi_from_ps_i,
    output logic [31:0]                   axi_to_ps_o,
    input  logic [31:0]                   S_AXIS_tdata_i,
    input  logic                          S_AXIS_tvalid_i,
    output logic [NUM_REGS*REG_WIDTH-1:0] cfg_o,
    output logic                          cfg_wr_o,
    output logic [3:0]                    cfg_addr_o,
    output logic                          busy_o
);

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_WRITE = 3'b001;
    localparam logic [2:0] OP_SNAP  = 3'b011;
`ifdef PDH_CMD_READBACK_EN
    localparam logic [2:0] OP_READ  = 3'b010;
`endif

    localparam logic [2:0] ST_OK       = 3'b000;
    localparam logic [2:0] ST_BAD_OP   = 3'b001;
    localparam logic [2:0] ST_BAD_ADDR = 3'b010;
    localparam logic [2:0] ST_TIMEOUT  = 3'b011;

    localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES);
    localparam logic [4:0]  NUM_REGS_W   = 5'(NUM_REGS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_EXEC   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                             state_q, state_d;
    logic [31:0]                        sync1_q, sync2_q;
    logic [31:0]                        cmd_q, cmd_d;
    logic [15:0]                        cnt_q, cnt_d;
    logic [NUM_REGS-1:0][REG_WIDTH-1:0] cfg_q, cfg_d;
    logic                               cfg_wr_q, cfg_wr_d;
    logic [3:0]                         cfg_addr_q, cfg_addr_d;
    logic                               ack_q, ack_d;
    logic [2:0]                         status_q, status_d;
    logic [3:0]                         raddr_q, raddr_d;
    logic [15:0]                        rdata_q, rdata_d;

    logic        exec_done;
    logic [2:0]  exec_status;
    logic [15:0] exec_rdata;
    logic [2:0]  cmd_op;
    logic [3:0]  cmd_addr;
    logic [15:0] cmd_data;
    logic        addr_ok;
    logic        unused_bits;

    assign cmd_op      = cmd_q[30:28];
    assign cmd_addr    = cmd_q[27:24];
    assign cmd_data    = cmd_q[15:0];
    assign addr_ok     = {1'b0, cmd_addr} < NUM_REGS_W;
    assign unused_bits = ^{cmd_q[23:16], cmd_data};

    assign axi_to_ps_o = {ack_q, status_q, raddr_q, 8'h00, rdata_q};
    assign cfg_o       = cfg_q;
    assign cfg_wr_o    = cfg_wr_q;
    assign cfg_addr_o  = cfg_addr_q;
    assign busy_o      = (state_q != S_IDLE);

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        cnt_d       = cnt_q;
        cfg_d       = cfg_q;
        cfg_wr_d    = 1'b0;
        cfg_addr_d  = cfg_addr_q;
        ack_d       = ack_q;
        status_d    = status_q;
        raddr_d     = raddr_q;
        rdata_d     = rdata_q;
        exec_done   = 1'b0;
        exec_status = ST_OK;
        exec_rdata  = '0;

        case (state_q)
            S_IDLE: begin
                if (sync2_q[31] != ack_q) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cmd_d   = sync2_q;
                    cnt_d   = '0;
                    state_d = S_EXEC;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_EXEC: begin
                exec_done = 1'b1;
                case (cmd_op)
                    OP_NOP: begin
                        exec_status = ST_OK;
                    end
                    OP_WRITE: begin
                        if (addr_ok) begin
                            for (int i = 0; i < NUM_REGS; i++) begin
                                if (cmd_addr == i[3:0]) begin
                                    cfg_d[i] = cmd_data[REG_WIDTH-1:0];
                                end
                            end
                            cfg_wr_d                     = 1'b1;
                            cfg_addr_d                   = cmd_addr;
                            exec_rdata[REG_WIDTH-1:0]    = cmd_data[REG_WIDTH-1:0];
                        end else begin
                            exec_status = ST_BAD_ADDR;
                        end
                    end
`ifdef PDH_CMD_READBACK_EN
                    OP_READ: begin
                        if (addr_ok) begin
                            for (int i = 0; i < NUM_REGS; i++) begin
                                if (cmd_addr == i[3:0]) begin
                                    exec_rdata[REG_WIDTH-1:0] = cfg_q[i];
                                end
                            end
                        end else begin
                            exec_status = ST_BAD_ADDR;
                        end
                    end
`endif
                    OP_SNAP: begin
                        // Valid wins over timeout when both land on the same cycle
                        if (cmd_addr > 4'd1) begin
                            exec_status = ST_BAD_ADDR;
                        end else if (S_AXIS_tvalid_i) begin
                            exec_rdata = cmd_addr[0] ? S_AXIS_tdata_i[31:16] : S_AXIS_tdata_i[15:0];
                        end else if (cnt_q == TIMEOUT_LAST) begin
                            exec_status = ST_TIMEOUT;
                        end else begin
                            exec_done = 1'b0;
                            cnt_d     = cnt_q + 16'd1;
                        end
                    end
                    default: begin
                        exec_status = ST_BAD_OP;
                    end
                endcase
                if (exec_done) begin
                    status_d = exec_status;
                    raddr_d  = cmd_addr;
                    rdata_d  = exec_rdata;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                // Data fields settled a cycle ago; only now flip the ack
                ack_d   = cmd_q[31];
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            sync1_q    <= '0;
            sync2_q    <= '0;
            cmd_q      <= '0;
            cnt_q      <= '0;
            cfg_q      <= '0;
            cfg_wr_q   <= 1'b0;
            cfg_addr_q <= '0;
            ack_q      <= 1'b0;
            status_q   <= '0;
            raddr_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= axi_from_ps_i;
            sync2_q    <= sync1_q;
            cmd_q      <= cmd_d;
            cnt_q      <= cnt_d;
            cfg_q      <= cfg_d;
            cfg_wr_q   <= cfg_wr_d;
            cfg_addr_q <= cfg_addr_d;
            ack_q      <= ack_d;
            status_q   <= status_d;
            raddr_q    <= raddr_d;
            rdata_q    <= rdata_d;
        end
    end

endmodule

// File: tb/tb_pdh_cmd_ctrl.sv
// tb/tb_pdh_cmd_ctrl.sv - scoreboard bench for pdh_cmd_ctrl
module tb_pdh_cmd_ctrl;

    localparam int NUM_REGS  = 8;
    localparam int REG_WIDTH = 16;
    localparam int SETTLE    = 4;
    localparam int TIMEOUT   = 1024;
    localparam int ACK_LAT   = SETTLE + 5;
    localparam int BUDGET    = 2 * (ACK_LAT + TIMEOUT) + 20;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_WRITE = 3'b001;
    localparam logic [2:0] OP_READ  = 3'b010;
    localparam logic [2:0] OP_SNAP  = 3'b011;
    localparam logic [2:0] ST_OK       = 3'b000;
    localparam logic [2:0] ST_BAD_OP   = 3'b001;
    localparam logic [2:0] ST_BAD_ADDR = 3'b010;
    localparam logic [2:0] ST_TIMEOUT  = 3'b011;

    logic                          clk;
    logic                          rst_n;
    logic [31:0]                   axi_from_ps_i;
    logic [31:0]                   axi_to_ps_o;
    logic [31:0]                   S_AXIS_tdata_i;
    logic                          S_AXIS_tvalid_i;
    logic [NUM_REGS*REG_WIDTH-1:0] cfg_o;
    logic                          cfg_wr_o;
    logic [3:0]                    cfg_addr_o;
    logic                          busy_o;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [19:0] wr_q[$];
    logic [15:0] model_cfg[NUM_REGS];

    pdh_cmd_ctrl #(
        .NUM_REGS      (NUM_REGS),
        .REG_WIDTH     (REG_WIDTH),
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .axi_from_ps_i  (axi_from_ps_i),
        .axi_to_ps_o    (axi_to_ps_o),
        .S_AXIS_tdata_i (S_AXIS_tdata_i),
        .S_AXIS_tvalid_i(S_AXIS_tvalid_i),
        .cfg_o          (cfg_o),
        .cfg_wr_o       (cfg_wr_o),
        .cfg_addr_o     (cfg_addr_o),
        .busy_o         (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic stb, input logic [2:0] op, input logic [3:0] addr,
                         input logic [15:0] data);
        axi_from_ps_i = {stb, op, addr, 8'hA5, data};
    endtask

    task automatic expect_resp(input logic ack, input logic [2:0] st, input logic [3:0] addr,
                               input logic [15:0] rd);
        exp_q.push_back({ack, st, addr, 8'h00, rd});
    endtask

    task automatic expect_write(input logic [3:0] addr, input logic [15:0] data);
        wr_q.push_back({addr, data});
        model_cfg[addr[2:0]] = data;
    endtask

    task automatic wait_ack(input string name, input logic val);
        int n;
        n = 0;
        while (axi_to_ps_o[31] !== val && n < BUDGET) begin
            cycles(1);
            n++;
        end
        check(name, 32'(axi_to_ps_o[31]), 32'(val));
    endtask

    task automatic check_cfg(input string tag);
        for (int i = 0; i < NUM_REGS; i++) begin
            check($sformatf("%s_cfg%0d", tag, i), 32'(cfg_o[i*REG_WIDTH +: REG_WIDTH]),
                  32'(model_cfg[i]));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_resp"}, axi_to_ps_o, 32'h0);
        check({tag, "_wr"}, 32'(cfg_wr_o), 32'h0);
        check({tag, "_addr"}, 32'(cfg_addr_o), 32'h0);
        check({tag, "_busy"}, 32'(busy_o), 32'h0);
        check_cfg(tag);
    endtask

    // Monitor: pops an expected response on every ack toggle and an expected write on every pulse
    initial begin
        logic        ack_prev;
        logic [31:0] e;
        logic [19:0] w;
        ack_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ack_prev = 1'b0;
            end else begin
                if (axi_to_ps_o[31] !== ack_prev) begin
                    ack_prev = axi_to_ps_o[31];
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_ack: got %h expected no response", axi_to_ps_o);
                    end else begin
                        e = exp_q.pop_front();
                        check("resp", axi_to_ps_o, e);
                    end
                end
                if (cfg_wr_o) begin
                    if (wr_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_write: got addr %0d expected no write", cfg_addr_o);
                    end else begin
                        w = wr_q.pop_front();
                        check("wr_addr", 32'(cfg_addr_o), 32'(w[19:16]));
                        check("wr_data", 32'(cfg_o[w[19:16]*REG_WIDTH +: REG_WIDTH]), 32'(w[15:0]));
                    end
                end
            end
        end
    end

    initial begin
        rst_n           = 1'b0;
        axi_from_ps_i   = '0;
        S_AXIS_tdata_i  = '0;
        S_AXIS_tvalid_i = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) model_cfg[i] = '0;
        cycles(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        cycles(2);

        // WRITE reg3 with exact pulse and ack timing
        expect_resp(1'b1, ST_OK, 4'd3, 16'h1234);
        expect_write(4'd3, 16'h1234);
        drive(1'b1, OP_WRITE, 4'd3, 16'h1234);
        cycles(ACK_LAT - 1);
        check("t1_wr_pulse", 32'(cfg_wr_o), 32'd1);
        check("t1_ack_early", 32'(axi_to_ps_o[31]), 32'd0);
        cycles(1);
        check("t1_ack_time", 32'(axi_to_ps_o[31]), 32'd1);
        check("t1_wr_single", 32'(cfg_wr_o), 32'd0);
        check("t1_cfg_addr", 32'(cfg_addr_o), 32'd3);
        check_cfg("t1");

`ifdef PDH_CMD_READBACK_EN
        expect_resp(1'b0, ST_OK, 4'd3, 16'h1234);
`else
        expect_resp(1'b0, ST_BAD_OP, 4'd3, 16'h0000);
`endif
        drive(1'b0, OP_READ, 4'd3, 16'hFFFF);
        wait_ack("t2_ack", 1'b0);

        expect_resp(1'b1, ST_BAD_ADDR, 4'd9, 16'h0000);
        drive(1'b1, OP_WRITE, 4'd9, 16'hDEAD);
        wait_ack("t3_ack", 1'b1);
        check_cfg("t3");

        // SNAP ch B, valid arrives while waiting in EXEC
        expect_resp(1'b0, ST_OK, 4'd1, 16'hBEEF);
        drive(1'b0, OP_SNAP, 4'd1, 16'h0000);
        cycles(ACK_LAT + 10);
        check("t4_busy_wait", 32'(busy_o), 32'd1);
        check("t4_no_ack_yet", 32'(axi_to_ps_o[31]), 32'd1);
        S_AXIS_tdata_i  = 32'hBEEF_0042;
        S_AXIS_tvalid_i = 1'b1;
        wait_ack("t4_ack", 1'b0);
        S_AXIS_tvalid_i = 1'b0;

        // SNAP ch A with valid already high: no extra latency
        S_AXIS_tvalid_i = 1'b1;
        expect_resp(1'b1, ST_OK, 4'd0, 16'h0042);
        drive(1'b1, OP_SNAP, 4'd0, 16'h0000);
        cycles(ACK_LAT - 1);
        check("t5_ack_early", 32'(axi_to_ps_o[31]), 32'd0);
        cycles(1);
        check("t5_ack_time", 32'(axi_to_ps_o[31]), 32'd1);
        S_AXIS_tvalid_i = 1'b0;

        expect_resp(1'b0, ST_TIMEOUT, 4'd1, 16'h0000);
        drive(1'b0, OP_SNAP, 4'd1, 16'h0000);
        cycles(ACK_LAT + TIMEOUT - 1);
        check("t6_ack_early", 32'(axi_to_ps_o[31]), 32'd1);
        cycles(1);
        check("t6_ack_time", 32'(axi_to_ps_o[31]), 32'd0);

        expect_resp(1'b1, ST_BAD_OP, 4'd2, 16'h0000);
        drive(1'b1, 3'b101, 4'd2, 16'h1111);
        wait_ack("t7_ack", 1'b1);

        expect_resp(1'b0, ST_OK, 4'd4, 16'h0000);
        drive(1'b0, OP_NOP, 4'd4, 16'h4444);
        wait_ack("t7n_ack", 1'b0);

        // Strobe glitch during SETTLE; final strobe equals new ack, so only one command
        expect_resp(1'b1, ST_OK, 4'd5, 16'h00AA);
        expect_write(4'd5, 16'h00AA);
        drive(1'b1, OP_WRITE, 4'd5, 16'h00AA);
        cycles(3);
        axi_from_ps_i[31] = 1'b0;
        cycles(1);
        axi_from_ps_i[31] = 1'b1;
        wait_ack("t8_ack", 1'b1);
        cycles(20);
        check("t8_idle", 32'(busy_o), 32'd0);
        check("t8_single", 32'(exp_q.size()), 32'd0);

        // Bus changes after the latch point: second command follows with the new word
        expect_resp(1'b0, ST_OK, 4'd6, 16'h0066);
        expect_write(4'd6, 16'h0066);
        expect_resp(1'b1, ST_OK, 4'd7, 16'h0077);
        expect_write(4'd7, 16'h0077);
        drive(1'b0, OP_WRITE, 4'd6, 16'h0066);
        cycles(5);
        drive(1'b1, OP_WRITE, 4'd7, 16'h0077);
        wait_ack("t9_ack_a", 1'b0);
        wait_ack("t9_ack_b", 1'b1);
        check_cfg("t9");

        // Reset during SNAP wait abandons the command
        drive(1'b0, OP_SNAP, 4'd0, 16'h0000);
        cycles(ACK_LAT + 5);
        check("t10_busy_wait", 32'(busy_o), 32'd1);
        rst_n = 1'b0;
        drive(1'b0, OP_SNAP, 4'd0, 16'h0000);
        for (int i = 0; i < NUM_REGS; i++) model_cfg[i] = '0;
        cycles(1);
        check_reset_outputs("t10_rst");
        rst_n = 1'b1;
        cycles(ACK_LAT + 10);
        check("t10_no_ack", axi_to_ps_o, 32'h0);
        check("t10_idle", 32'(busy_o), 32'd0);

        // Strobe already high at reset release runs a command
        rst_n = 1'b0;
        drive(1'b1, OP_NOP, 4'd3, 16'h0000);
        expect_resp(1'b1, ST_OK, 4'd3, 16'h0000);
        cycles(2);
        rst_n = 1'b1;
        wait_ack("t11_ack", 1'b1);

        cycles(5);
        check("queues_empty", 32'(exp_q.size() + wr_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
